// File: rtl/regfile_dump_if.sv
// Read-port plus output-stream bundle between the dump sequencer, the register
// file it reads, and the downstream consumer of the tagged byte stream.
interface regfile_dump_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [DW-1:0] dout;
  logic [AW-1:0] dout_addr;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output ra, dout, dout_addr, dout_valid,
    input  rd, dout_ready
  );

  modport slave (
    input  ra, dout, dout_addr, dout_valid,
    output rd, dout_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Register-file dump sequencer: walks FIRST_REG..LAST_REG over one read port and
// streams each value, tagged with its address, on a valid/ready interface.
module regfile_dump #(
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  regfile_dump_if.master       bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW-1:0] FIRST_A = FIRST_REG[AW-1:0];
  localparam logic [AW-1:0] LAST_A  = LAST_REG[AW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] ra, ra_d;
  logic [DW-1:0] dout, dout_d;
  logic [AW-1:0] dout_addr, dout_addr_d;
  logic          dout_valid, dout_valid_d;
  logic          busy_d, done_d;

  // NOTE: every signal gets a hold/default value before the case statement so
  // no path leaves it unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d      = state;
    ra_d         = ra;
    dout_d       = dout;
    dout_addr_d  = dout_addr;
    dout_valid_d = dout_valid;
    busy_d       = busy;
    done_d       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          ra_d    = FIRST_A;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          dout_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          dout_d       = bus.rd;
          dout_addr_d  = ra;
          dout_valid_d = 1'b1;
          state_d      = SEND;
        end
      end

      SEND: begin
        // Abort outranks a beat accepted in the same cycle: no beat, no done.
        if (abort) begin
          dout_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
          if (ra == LAST_A) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ra_d    = ra + 1'b1;
            state_d = LOAD;
          end
        end
      end

      default: begin
        dout_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ra         <= FIRST_A;
      dout       <= '0;
      dout_addr  <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      ra         <= ra_d;
      dout       <= dout_d;
      dout_addr  <= dout_addr_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign bus.ra         = ra;
  assign bus.dout       = dout;
  assign bus.dout_addr  = dout_addr;
  assign bus.dout_valid = dout_valid;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, backpressure, sub-range dump,
// abort, asynchronous reset mid-dump, and late register update.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, start2, abort2;
  logic busy1, done1, busy2, done2;
  logic [7:0] regs [8];

  regfile_dump_if #(.DW(8), .AW(3)) bus1 ();
  regfile_dump_if #(.DW(8), .AW(3)) bus2 ();

  regfile_dump #(.DW(8), .AW(3), .FIRST_REG(0), .LAST_REG(7)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bus(bus1), .busy(busy1), .done(done1)
  );

  regfile_dump #(.DW(8), .AW(3), .FIRST_REG(2), .LAST_REG(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .bus(bus2), .busy(busy2), .done(done2)
  );

  // Register file model: register 0 always reads zero.
  assign bus1.rd = (bus1.ra == 3'd0) ? 8'h00 : regs[bus1.ra];
  assign bus2.rd = (bus2.ra == 3'd0) ? 8'h00 : regs[bus2.ra];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat monitors, sampled on the falling edge.
  int         cyc = 0;
  logic [2:0] q_addr [$];
  logic [7:0] q_data [$];
  int         q_cyc  [$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_busy = 1'b0;
  logic [2:0] q2_addr [$];
  logic [7:0] q2_data [$];
  int         done2_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus1.dout_valid && bus1.dout_ready && !abort) begin
      q_addr.push_back(bus1.dout_addr);
      q_data.push_back(bus1.dout);
      q_cyc.push_back(cyc);
    end
    if (done1) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_busy <= busy1;
    end
    if (rst && bus2.dout_valid && bus2.dout_ready && !abort2) begin
      q2_addr.push_back(bus2.dout_addr);
      q2_data.push_back(bus2.dout);
    end
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done1 && n < max) begin
      tick();
      n++;
    end
    check(tag, done1, 1'b1);
  endtask

  task automatic wait_beat(input string tag, input logic [2:0] a, input int max);
    int n = 0;
    while (!(bus1.dout_valid && bus1.dout_addr == a) && n < max) begin
      tick();
      n++;
    end
    check(tag, bus1.dout_valid && (bus1.dout_addr == a), 1'b1);
  endtask

  function automatic logic [7:0] exp_val(input int a, input int ovr_addr, input logic [7:0] ovr_val);
    if (a == 0)        return 8'h00;
    if (a == ovr_addr) return ovr_val;
    return 8'(a * 8'h11);
  endfunction

  task automatic check_beats(input string tag, input int b, input int cnt,
                             input int ovr_addr, input logic [7:0] ovr_val);
    check($sformatf("%s_count", tag), q_addr.size() - b, cnt);
    for (int k = 0; k < cnt; k++) begin
      if (b + k < q_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, k), q_addr[b+k], k);
        check($sformatf("%s_data%0d", tag, k), q_data[b+k], exp_val(k, ovr_addr, ovr_val));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, d, b2, d2, n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    bus1.dout_ready = 1'b0;
    bus2.dout_ready = 1'b0;
    regs[0] = 8'hFF;
    for (int i = 1; i < 8; i++) regs[i] = 8'(i * 8'h11);

    // Reset values
    #12;
    check("rst_ra",        bus1.ra, 3'd0);
    check("rst_dout",      bus1.dout, 8'h00);
    check("rst_dout_addr", bus1.dout_addr, 3'd0);
    check("rst_valid",     bus1.dout_valid, 1'b0);
    check("rst_busy",      busy1, 1'b0);
    check("rst_done",      done1, 1'b0);
    check("rst_ra_dut2",   bus2.ra, 3'd2);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // 1: full dump, no backpressure
    bus1.dout_ready = 1'b1;
    b = q_addr.size(); d = done_cnt;
    pulse_start();
    check("t1_busy_after_start",  busy1, 1'b1);
    check("t1_valid_after_start", bus1.dout_valid, 1'b0);
    tick();
    check("t1_first_valid", bus1.dout_valid, 1'b1);
    check("t1_first_addr",  bus1.dout_addr, 3'd0);
    check("t1_first_data",  bus1.dout, 8'h00);
    wait_done("t1_done", 40);
    check("t1_busy_at_done", busy1, 1'b0);
    tick();
    check("t1_done_pulse_end", done1, 1'b0);
    check_beats("t1", b, 8, -1, 8'h00);
    for (int k = 1; k < 8; k++)
      if (b + k < q_cyc.size())
        check($sformatf("t1_spacing%0d", k), q_cyc[b+k] - q_cyc[b+k-1], 2);
    check("t1_done_count", done_cnt - d, 1);
    check("t1_done_latency", done_cyc - q_cyc[q_cyc.size()-1], 1);
    check("t1_done_busy", done_busy, 1'b0);

    // 2: backpressure on register 3 beat
    b = q_addr.size();
    pulse_start();
    wait_beat("t2_reach3", 3'd3, 20);
    bus1.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold_valid%0d", i), bus1.dout_valid, 1'b1);
      check($sformatf("t2_hold_addr%0d", i),  bus1.dout_addr, 3'd3);
      check($sformatf("t2_hold_data%0d", i),  bus1.dout, 8'h33);
      tick();
    end
    bus1.dout_ready = 1'b1;
    wait_done("t2_done", 40);
    tick();
    check_beats("t2", b, 8, -1, 8'h00);

    // 3: sub-range instance dumps 2..4 only
    bus2.dout_ready = 1'b1;
    b2 = q2_addr.size(); d2 = done2_cnt;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 30) begin tick(); n++; end
    check("t3_done", done2, 1'b1);
    tick();
    check("t3_count", q2_addr.size() - b2, 3);
    for (int k = 0; k < 3; k++)
      if (b2 + k < q2_addr.size()) begin
        check($sformatf("t3_addr%0d", k), q2_addr[b2+k], k + 2);
        check($sformatf("t3_data%0d", k), q2_data[b2+k], 8'((k + 2) * 8'h11));
      end
    check("t3_done_count", done2_cnt - d2, 1);
    check("t3_busy_end", busy2, 1'b0);

    // 4: abort during addr-5 SEND, then restart
    b = q_addr.size(); d = done_cnt;
    pulse_start();
    wait_beat("t4_reach5", 3'd5, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid_after_abort", bus1.dout_valid, 1'b0);
    check("t4_busy_after_abort",  busy1, 1'b0);
    check("t4_done_after_abort",  done1, 1'b0);
    tick(); tick(); tick();
    check("t4_no_done",     done_cnt - d, 0);
    check("t4_beats_kept",  q_addr.size() - b, 5);
    check("t4_still_idle",  bus1.dout_valid, 1'b0);
    b = q_addr.size();
    pulse_start();
    tick();
    check("t4_restart_addr", bus1.dout_addr, 3'd0);
    wait_done("t4_restart_done", 40);
    tick();
    check_beats("t4r", b, 8, -1, 8'h00);

    // 5: asynchronous reset mid-dump, then start while busy is ignored
    pulse_start();
    wait_beat("t5_reach2", 3'd2, 20);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_ra",    bus1.ra, 3'd0);
    check("t5_rst_dout",  bus1.dout, 8'h00);
    check("t5_rst_addr",  bus1.dout_addr, 3'd0);
    check("t5_rst_valid", bus1.dout_valid, 1'b0);
    check("t5_rst_busy",  busy1, 1'b0);
    check("t5_rst_done",  done1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_idle_busy",  busy1, 1'b0);
    check("t5_idle_valid", bus1.dout_valid, 1'b0);
    b = q_addr.size(); d = done_cnt;
    pulse_start();
    tick(); tick();
    pulse_start();
    wait_done("t5_done", 40);
    tick();
    check_beats("t5", b, 8, -1, 8'h00);
    check("t5_done_count", done_cnt - d, 1);

    // 6: register 6 rewritten while register 2 is on the stream
    b = q_addr.size();
    pulse_start();
    wait_beat("t6_reach2", 3'd2, 20);
    regs[6] = 8'hA5;
    wait_done("t6_done", 40);
    tick();
    check_beats("t6", b, 8, 6, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
